// File: rtl/seq_det_ctrl_if.sv
// Request, serial-data and status bundle for seq_det_ctrl.
// The abort_i signal exists only when SEQ_DET_CTRL_ABORT_EN is defined.
interface seq_det_ctrl_if #(
  parameter int PAT_W = 5,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             start_i;
  logic [PAT_W-1:0] pattern_i;
  logic [LEN_W-1:0] len_i;
  logic             d_valid_i;
  logic             d_i;
`ifdef SEQ_DET_CTRL_ABORT_EN
  logic             abort_i;
`endif
  logic             d_ready_o;
  logic             match_o;
  logic [CNT_W-1:0] match_cnt_o;
  logic             busy_o;
  logic             done_o;

  modport master (
`ifdef SEQ_DET_CTRL_ABORT_EN
    output abort_i,
`endif
    output start_i, pattern_i, len_i, d_valid_i, d_i,
    input  d_ready_o, match_o, match_cnt_o, busy_o, done_o
  );

  modport slave (
`ifdef SEQ_DET_CTRL_ABORT_EN
    input  abort_i,
`endif
    input  start_i, pattern_i, len_i, d_valid_i, d_i,
    output d_ready_o, match_o, match_cnt_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Serial pattern-detector job controller: counts overlapping matches of a latched
// pattern over a fixed-length bit stream. Optional abort via SEQ_DET_CTRL_ABORT_EN.
module seq_det_ctrl #(
  parameter int PAT_W = 5,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  seq_det_ctrl_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [PAT_W-1:0]  pat_r;
  logic [PAT_W-1:0]  hist_r;
  logic [PAT_W-1:0]  cand_s;
  logic [LEN_W-1:0]  rem_r;
  logic [FILL_W-1:0] fill_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              match_r;
  logic              busy_r;
  logic              done_r;
  logic              abort_s;
  logic              run_s;
  logic              ready_s;
  logic              accept_s;
  logic              start_ok_s;
  logic              hit_s;
  logic              last_s;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      cnt_sat_inc = v;
    end else begin
      cnt_sat_inc = v + CNT_W'(1);
    end
  endfunction

  function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] v);
    if (v >= FILL_MAX) begin
      fill_sat_inc = FILL_MAX;
    end else begin
      fill_sat_inc = v + FILL_W'(1);
    end
  endfunction

`ifdef SEQ_DET_CTRL_ABORT_EN
  assign abort_s = bus.abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // The candidate window is the history with the incoming bit appended.
  assign cand_s     = {hist_r[PAT_W-2:0], bus.d_i};
  assign run_s      = (state_r == ST_RUN);
  assign ready_s    = run_s & ~abort_s;
  assign accept_s   = ready_s & bus.d_valid_i;
  assign start_ok_s = (state_r == ST_IDLE) & bus.start_i;
  assign last_s     = (rem_r == LEN_W'(1));
  assign hit_s      = accept_s & (cand_s == pat_r) & (fill_r >= FILL_THR);

  assign bus.d_ready_o   = ready_s;
  assign bus.match_o     = match_r;
  assign bus.match_cnt_o = cnt_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;

  // Next-state decode; any corrupted encoding recovers to IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != {LEN_W{1'b0}}) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_nxt_s = ST_DONE;
        end else if (accept_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus busy/done flags registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN) | (state_nxt_s == ST_DONE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Job context: latched pattern, remaining bits, shift history and fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_r  <= {PAT_W{1'b0}};
      rem_r  <= {LEN_W{1'b0}};
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else if (start_ok_s) begin
      pat_r  <= bus.pattern_i;
      rem_r  <= bus.len_i;
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else if (accept_s) begin
      pat_r  <= pat_r;
      rem_r  <= rem_r - LEN_W'(1);
      hist_r <= cand_s;
      fill_r <= fill_sat_inc(fill_r);
    end else begin
      pat_r  <= pat_r;
      rem_r  <= rem_r;
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Match pulse and saturating count; the count holds after DONE until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      match_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      match_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (hit_s) begin
      match_r <= 1'b1;
      cnt_r   <= cnt_sat_inc(cnt_r);
    end else begin
      match_r <= 1'b0;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed jobs plus randomized jobs checked
// against a bit-history reference model; a CNT_W=2 twin checks count saturation.
module tb_seq_det_ctrl;

  localparam int PW = 5;

  logic clk;
  logic rst_ni;

  seq_det_ctrl_if #(.PAT_W(PW), .LEN_W(8), .CNT_W(8)) bus ();
  seq_det_ctrl_if #(.PAT_W(PW), .LEN_W(8), .CNT_W(2)) bus2 ();

  seq_det_ctrl #(.PAT_W(PW), .LEN_W(8), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  seq_det_ctrl #(.PAT_W(PW), .LEN_W(8), .CNT_W(2)) dut_sat (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus2.slave)
  );

  assign bus2.start_i   = bus.start_i;
  assign bus2.pattern_i = bus.pattern_i;
  assign bus2.len_i     = bus.len_i;
  assign bus2.d_valid_i = bus.d_valid_i;
  assign bus2.d_i       = bus.d_i;
`ifdef SEQ_DET_CTRL_ABORT_EN
  assign bus2.abort_i   = bus.abort_i;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 running, 2 done.
  int          m_mode  = 0;
  int          m_len   = 0;
  int          m_pat   = 0;
  int          m_cnt   = 0;
  bit          m_match = 1'b0;
  bit          m_ab    = 1'b0;
  bit          m_bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int window_val();
    int w = 0;
    for (int i = m_bits.size() - PW; i < m_bits.size(); i++) w = w * 2 + int'(m_bits[i]);
    return w;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_outputs();
    chk("d_ready",   bus.d_ready_o,    32'((m_mode == 1) && !m_ab));
    chk("busy",      bus.busy_o,       32'(m_mode != 0));
    chk("done",      bus.done_o,       32'(m_mode == 2));
    chk("match",     bus.match_o,      32'(m_match));
    chk("match_cnt", bus.match_cnt_o,  32'(sat(m_cnt, 255)));
    chk("sat_match", bus2.match_o,     32'(m_match));
    chk("sat_cnt",   bus2.match_cnt_o, 32'(sat(m_cnt, 3)));
  endtask

  task automatic model_step(input bit st, input int pat, input int len,
                            input bit vld, input bit d, input bit ab);
    bit nm = 1'b0;
    bit ab_e = 1'b0;
`ifdef SEQ_DET_CTRL_ABORT_EN
    ab_e = ab;
`endif
    m_ab = ab_e;
    if (m_mode == 0) begin
      if (st) begin
        m_pat = pat;
        m_len = len;
        m_cnt = 0;
        m_bits.delete();
        m_mode = (len != 0) ? 1 : 2;
      end
    end else if (m_mode == 1) begin
      if (ab_e) begin
        m_mode = 2;
      end else if (vld) begin
        m_bits.push_back(d);
        if (m_bits.size() >= PW && window_val() == m_pat) begin
          nm = 1'b1;
          m_cnt++;
        end
        if (m_bits.size() == m_len) m_mode = 2;
      end
    end else begin
      m_mode = 0;
    end
    m_match = nm;
  endtask

  task automatic cycle(input bit st, input int pat, input int len,
                       input bit vld, input bit d, input bit ab);
    @(negedge clk);
    check_outputs();
    bus.start_i   = st;
    bus.pattern_i = 5'(pat);
    bus.len_i     = 8'(len);
    bus.d_valid_i = vld;
    bus.d_i       = d;
`ifdef SEQ_DET_CTRL_ABORT_EN
    bus.abort_i   = ab;
`endif
    model_step(st, pat, len, vld, d, ab);
  endtask

  // gap: 0 none, 1 alternate cycles, 2 random. bits holds the stream MSB-first.
  task automatic run_job(input int pat, input int len, input logic [63:0] bits,
                         input int gap, input int abort_after);
    int  guard = 0;
    bit  tog   = 1'b0;
    bit  vld;
    bit  ab;
    bit  d;
    cycle(1'b1, pat, len, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
    while (m_mode == 1 && guard < 400) begin
      if (gap == 0) vld = 1'b1;
      else if (gap == 1) begin vld = tog; tog = ~tog; end
      else vld = ($urandom_range(99) >= 35);
      ab = (abort_after >= 0) && (m_bits.size() == abort_after);
      d  = bits[len - 1 - m_bits.size()];
      cycle(1'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(255)),
            vld, vld ? d : 1'($urandom_range(1)), ab);
      guard++;
    end
    while (m_mode != 0 && guard < 400) begin
      cycle((m_mode == 2) ? 1'($urandom_range(1)) : 1'b0, int'($urandom_range(31)),
            int'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      guard++;
    end
    n_assert++;
    assert (guard < 400) else begin
      n_fail++;
      $error("FAIL job_timeout observed=%0d expected=<400", guard);
    end
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] rb;
    int          rp;
    int          rl;

    rst_ni        = 1'b0;
    bus.start_i   = 1'b0;
    bus.pattern_i = 5'd0;
    bus.len_i     = 8'd0;
    bus.d_valid_i = 1'b0;
    bus.d_i       = 1'b0;
`ifdef SEQ_DET_CTRL_ABORT_EN
    bus.abort_i   = 1'b0;
`endif
    #2;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Gapless and alternating-gap versions of the same job.
    run_job(5'b10110, 8, 64'b10110110, 0, -1);
    chk("r033_cnt", bus.match_cnt_o, 32'd2);
    run_job(5'b10110, 8, 64'b10110110, 1, -1);
    chk("r034_cnt", bus.match_cnt_o, 32'd2);

    // Zero-length job goes straight to DONE.
    run_job(5'b10110, 0, 64'd0, 0, -1);
    chk("r035_cnt", bus.match_cnt_o, 32'd0);

    // Nine ones against 11111: five matches, two-bit counter saturates.
    run_job(5'b11111, 9, 64'h1FF, 0, -1);
    chk("r036_cnt", bus.match_cnt_o, 32'd5);
    chk("r036_sat", bus2.match_cnt_o, 32'd3);

    // Reset after three accepted bits aborts silently.
    cycle(1'b1, 5'b10110, 8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    m_mode  = 0;
    m_match = 1'b0;
    m_cnt   = 0;
    m_bits.delete();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_ni = 1'b1;
    run_job(5'b10110, 8, 64'b10110110, 0, -1);
    chk("r037_cnt", bus.match_cnt_o, 32'd2);

`ifdef SEQ_DET_CTRL_ABORT_EN
    run_job(5'b10110, 8, 64'b10110110, 0, 6);
    chk("r038_cnt", bus.match_cnt_o, 32'd1);
`endif

    // Randomized jobs, streams biased toward the pattern to provoke matches.
    for (int j = 0; j < 30; j++) begin
      rp = int'($urandom_range(31));
      rl = int'($urandom_range(40));
      rb = 64'd0;
      for (int i = 0; i < rl; i++) begin
        rb[rl - 1 - i] = ($urandom_range(3) != 0) ? rp[PW - 1 - (i % PW)]
                                                  : 1'($urandom_range(1));
      end
      run_job(rp, rl, rb, j % 3, -1);
      for (int k = 0; k < int'($urandom_range(2)); k++) begin
        cycle(1'b0, 0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
